// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable timer/counter.
package timer_pkg;

  // Counter FSM: running normally, or parked after a one-shot wrap.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } timer_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : timer_pkg

// File: rtl/tick_prescaler.sv
// Clock prescaler: produces a step every prescale+1 enabled cycles.
// The step is decoded from the registered phase count and is only used
// internally to qualify register updates in the counter.
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step
);

  logic [PRESCALE_W-1:0] pre_cnt_r;
  logic                  hit_s;

  // Terminal phase detect; a lowered prescale lets the count run on and
  // wrap through all-ones back to zero instead of being clipped.
  always_comb begin
    hit_s = 1'b0;
    if (pre_cnt_r == prescale) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    step = en & hit_s;
  end

  // Phase counter: cleared by load/halt, frozen while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= {PRESCALE_W{1'b0}};
    end else if (clr) begin
      pre_cnt_r <= {PRESCALE_W{1'b0}};
    end else if (en) begin
      if (hit_s) begin
        pre_cnt_r <= {PRESCALE_W{1'b0}};
      end else begin
        pre_cnt_r <= pre_cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pre_cnt_r <= pre_cnt_r;
    end
  end

endmodule : tick_prescaler

// File: rtl/timer_counter.sv
// Programmable timer/counter: prescaled up/down count with modulo wrap,
// parallel load, one-shot halt, compare match and sticky overflow.
// Every output comes straight from a flop.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  oneshot,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      modulo,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic                  clr_flags,
  output logic [WIDTH-1:0]      out,
  output logic                  tick,
  output logic                  cmp_match,
  output logic                  ovf_sticky,
  output logic                  running
);

  timer_state_e     state_r;
  timer_state_e     state_nxt_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_nxt_s;
  logic             wrap_s;
  logic             tick_r;
  logic             cmp_match_r;
  logic             ovf_r;
  logic             running_r;
  logic             step_s;
  logic             pre_en_s;
  logic             pre_clr_s;

  // Prescaler only advances while running; parked at phase 0 when halted or loaded.
  always_comb begin
    pre_en_s  = en & (state_r == ST_RUN);
    pre_clr_s = load | (state_r == ST_HALT);
  end

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (pre_en_s),
    .clr      (pre_clr_s),
    .prescale (prescale),
    .step     (step_s)
  );

  // Next count value and wrap detection; load overrides any coincident step.
  always_comb begin
    out_nxt_s = out_r;
    wrap_s    = 1'b0;
    if (load) begin
      out_nxt_s = load_val;
    end else if (step_s) begin
      if (dir == DIR_UP) begin
        if (out_r >= modulo) begin
          out_nxt_s = {WIDTH{1'b0}};
          wrap_s    = 1'b1;
        end else begin
          out_nxt_s = out_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        if (out_r == {WIDTH{1'b0}}) begin
          out_nxt_s = modulo;
          wrap_s    = 1'b1;
        end else begin
          out_nxt_s = out_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      out_nxt_s = out_r;
    end
  end

  // FSM next state: a one-shot wrap parks the counter until the next load.
  always_comb begin
    state_nxt_s = state_r;
    if (load) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (wrap_s && oneshot) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HALT: state_nxt_s = ST_HALT;
        default: state_nxt_s = ST_RUN;
      endcase
    end
  end

  // State, count and output flags; compare is taken from the next count so
  // it lines up with out in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RUN;
      out_r       <= {WIDTH{1'b0}};
      tick_r      <= 1'b0;
      cmp_match_r <= 1'b0;
      ovf_r       <= 1'b0;
      running_r   <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_r       <= out_nxt_s;
      tick_r      <= wrap_s;
      cmp_match_r <= (out_nxt_s == cmp_val);
      running_r   <= (state_nxt_s == ST_RUN);
      if (wrap_s) begin
        ovf_r <= 1'b1;
      end else if (clr_flags) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign out        = out_r;
  assign tick       = tick_r;
  assign cmp_match  = cmp_match_r;
  assign ovf_sticky = ovf_r;
  assign running    = running_r;

endmodule : timer_counter

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

  localparam int WIDTH      = 17;
  localparam int PRESCALE_W = 8;

  logic                  clk;
  logic                  reset_n;
  logic                  en;
  logic                  dir;
  logic                  oneshot;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      modulo;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      cmp_val;
  logic                  clr_flags;
  logic [WIDTH-1:0]      out;
  logic                  tick;
  logic                  cmp_match;
  logic                  ovf_sticky;
  logic                  running;

  int n_cmp;
  int n_fail;

  timer_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .dir        (dir),
    .oneshot    (oneshot),
    .load       (load),
    .load_val   (load_val),
    .modulo     (modulo),
    .prescale   (prescale),
    .cmp_val    (cmp_val),
    .clr_flags  (clr_flags),
    .out        (out),
    .tick       (tick),
    .cmp_match  (cmp_match),
    .ovf_sticky (ovf_sticky),
    .running    (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse reset over one edge, release at the following negedge.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    en = 1'b1; dir = 1'b0; oneshot = 1'b0; load = 1'b0;
    load_val = 17'd0; modulo = 17'd4; prescale = 8'd0;
    cmp_val = 17'h1FFFF; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    set_defaults();
    do_reset();
    n_cmp++; if (out !== 17'd0) begin n_fail++; $display("FAIL reset_out got=%0h exp=0", out); end
    n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL reset_running got=%b exp=1", running); end
  endtask

  task automatic test_up_wrap();
    logic [WIDTH-1:0] eo [6];
    logic et [6];
    logic ev [6];
    eo = '{17'd1, 17'd2, 17'd3, 17'd4, 17'd0, 17'd1};
    et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    set_defaults();
    modulo = 17'd4;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step_clk();
      n_cmp++; if (out !== eo[i]) begin n_fail++; $display("FAIL up_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_fail++; $display("FAIL up_tick[%0d] got=%b exp=%b", i, tick, et[i]); end
      n_cmp++; if (ovf_sticky !== ev[i]) begin n_fail++; $display("FAIL up_ovf[%0d] got=%b exp=%b", i, ovf_sticky, ev[i]); end
    end
  endtask

  task automatic test_prescale();
    logic [WIDTH-1:0] eo [7];
    eo = '{17'd0, 17'd0, 17'd1, 17'd1, 17'd1, 17'd2, 17'd2};
    set_defaults();
    modulo = 17'h1FFFF;
    prescale = 8'd2;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step_clk();
      n_cmp++; if (out !== eo[i]) begin n_fail++; $display("FAIL pre_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      n_cmp++; if (out !== 17'd2) begin n_fail++; $display("FAIL pre_frozen[%0d] got=%0d exp=2", i, out); end
    end
    en = 1'b1;
    step_clk();
    n_cmp++; if (out !== 17'd2) begin n_fail++; $display("FAIL pre_resume0 got=%0d exp=2", out); end
    step_clk();
    n_cmp++; if (out !== 17'd3) begin n_fail++; $display("FAIL pre_resume1 got=%0d exp=3", out); end
  endtask

  task automatic test_down_load();
    logic [WIDTH-1:0] eo [5];
    logic et [5];
    logic ec [5];
    eo = '{17'd2, 17'd1, 17'd0, 17'd5, 17'd4};
    et = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    set_defaults();
    dir = 1'b1;
    modulo = 17'd5;
    cmp_val = 17'd0;
    load = 1'b1;
    load_val = 17'd2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_clk();
      load = 1'b0;
      n_cmp++; if (out !== eo[i]) begin n_fail++; $display("FAIL dn_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_fail++; $display("FAIL dn_tick[%0d] got=%b exp=%b", i, tick, et[i]); end
      n_cmp++; if (cmp_match !== ec[i]) begin n_fail++; $display("FAIL dn_cmp[%0d] got=%b exp=%b", i, cmp_match, ec[i]); end
    end
  endtask

  task automatic test_oneshot();
    logic [WIDTH-1:0] eo [6];
    logic et [6];
    logic er [6];
    eo = '{17'd1, 17'd2, 17'd3, 17'd0, 17'd0, 17'd0};
    et = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    set_defaults();
    oneshot = 1'b1;
    modulo = 17'd3;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step_clk();
      n_cmp++; if (out !== eo[i]) begin n_fail++; $display("FAIL os_out[%0d] got=%0d exp=%0d", i, out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_fail++; $display("FAIL os_tick[%0d] got=%b exp=%b", i, tick, et[i]); end
      n_cmp++; if (running !== er[i]) begin n_fail++; $display("FAIL os_run[%0d] got=%b exp=%b", i, running, er[i]); end
    end
    oneshot = 1'b0;
    step_clk();
    n_cmp++; if (out !== 17'd0) begin n_fail++; $display("FAIL os_noresume_out got=%0d exp=0", out); end
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL os_noresume_run got=%b exp=0", running); end
    oneshot = 1'b1;
    load = 1'b1;
    load_val = 17'd1;
    step_clk();
    load = 1'b0;
    n_cmp++; if (out !== 17'd1) begin n_fail++; $display("FAIL os_load_out got=%0d exp=1", out); end
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL os_load_run got=%b exp=1", running); end
    step_clk();
    n_cmp++; if (out !== 17'd2) begin n_fail++; $display("FAIL os_cnt2 got=%0d exp=2", out); end
    step_clk();
    n_cmp++; if (out !== 17'd3) begin n_fail++; $display("FAIL os_cnt3 got=%0d exp=3", out); end
  endtask

  task automatic test_priority();
    set_defaults();
    modulo = 17'd3;
    do_reset();
    step_clk(); step_clk(); step_clk();
    n_cmp++; if (out !== 17'd3) begin n_fail++; $display("FAIL pr_at_mod got=%0d exp=3", out); end
    load = 1'b1;
    load_val = 17'd2;
    step_clk();
    load = 1'b0;
    n_cmp++; if (out !== 17'd2) begin n_fail++; $display("FAIL pr_load_out got=%0d exp=2", out); end
    n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL pr_load_tick got=%b exp=0", tick); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL pr_load_ovf got=%b exp=0", ovf_sticky); end
    step_clk();
    n_cmp++; if (out !== 17'd3) begin n_fail++; $display("FAIL pr_cnt3 got=%0d exp=3", out); end
    clr_flags = 1'b1;
    step_clk();
    n_cmp++; if (tick !== 1'b1) begin n_fail++; $display("FAIL pr_wrap_tick got=%b exp=1", tick); end
    n_cmp++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL pr_wrapclr_ovf got=%b exp=1", ovf_sticky); end
    step_clk();
    clr_flags = 1'b0;
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL pr_clr_ovf got=%b exp=0", ovf_sticky); end
    n_cmp++; if (out !== 17'd1) begin n_fail++; $display("FAIL pr_clr_out got=%0d exp=1", out); end
  endtask

  task automatic test_async_reset();
    set_defaults();
    modulo = 17'd3;
    do_reset();
    load = 1'b1;
    load_val = 17'd3;
    step_clk();
    load = 1'b0;
    step_clk();
    n_cmp++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ar_pre_ovf got=%b exp=1", ovf_sticky); end
    modulo = 17'h1FFFF;
    load = 1'b1;
    load_val = 17'h0ABC;
    step_clk();
    load = 1'b0;
    en = 1'b0;
    n_cmp++; if (out !== 17'h0ABC) begin n_fail++; $display("FAIL ar_loaded got=%0h exp=abc", out); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out !== 17'd0) begin n_fail++; $display("FAIL ar_out got=%0h exp=0", out); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ar_ovf got=%b exp=0", ovf_sticky); end
    n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL ar_tick got=%b exp=0", tick); end
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    step_clk();
    n_cmp++; if (out !== 17'd1) begin n_fail++; $display("FAIL ar_resume1 got=%0d exp=1", out); end
    step_clk();
    n_cmp++; if (out !== 17'd2) begin n_fail++; $display("FAIL ar_resume2 got=%0d exp=2", out); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    set_defaults();
    test_reset();
    test_up_wrap();
    test_prescale();
    test_down_load();
    test_oneshot();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_timer_counter
